// File: rtl/neural_acq_pkg.sv
// Shared types and constants for the sys_clk acquisition stages.
// The slot view matches the default 4-bit channel / 16-bit sample configuration.
package neural_acq_pkg;

  localparam int SEQ_W           = 8;
  localparam int DEF_CH_ID_WIDTH = 4;
  localparam int DEF_DATA_WIDTH  = 16;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_FILL = 1'b1;

  typedef struct packed {
    logic [DEF_CH_ID_WIDTH-1:0] ch;
    logic [DEF_DATA_WIDTH-1:0]  data;
  } slot_t;

  function automatic int cnt_width(input int slots);
    return $clog2(slots + 1);
  endfunction

endpackage

// File: rtl/neural_sync_fifo.sv
// Single-clock show-ahead FIFO: rd_data presents the head word whenever not empty.
// A write into a full FIFO only succeeds when a read frees a slot in the same cycle.
module neural_sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   level
);

  localparam logic [DEPTH_LOG2:0] DEPTH = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [DATA_WIDTH-1:0] mem_r [2**DEPTH_LOG2];
  logic [DEPTH_LOG2-1:0] wr_ptr_r;
  logic [DEPTH_LOG2-1:0] rd_ptr_r;
  logic [DEPTH_LOG2:0]   level_r;
  logic                  full_s;
  logic                  empty_s;
  logic                  do_rd_s;
  logic                  do_wr_s;

  assign full_s  = (level_r == DEPTH);
  assign empty_s = (level_r == {(DEPTH_LOG2+1){1'b0}});
  assign do_rd_s = rd_en && !empty_s;
  assign do_wr_s = wr_en && (!full_s || do_rd_s);

  // storage array; contents are don't-care until written
  always_ff @(posedge sys_clk) begin
    if (do_wr_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // pointer and occupancy bookkeeping
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wr_ptr_r <= {DEPTH_LOG2{1'b0}};
      rd_ptr_r <= {DEPTH_LOG2{1'b0}};
      level_r  <= {(DEPTH_LOG2+1){1'b0}};
    end else begin
      if (do_wr_s) begin
        wr_ptr_r <= wr_ptr_r + {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
      end
      if (do_rd_s) begin
        rd_ptr_r <= rd_ptr_r + {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
      end
      case ({do_wr_s, do_rd_s})
        2'b10:   level_r <= level_r + {{DEPTH_LOG2{1'b0}}, 1'b1};
        2'b01:   level_r <= level_r - {{DEPTH_LOG2{1'b0}}, 1'b1};
        default: level_r <= level_r;
      endcase
    end
  end

  // head word is forced to zero while empty so nothing stale leaks out after reset
  assign rd_data = empty_s ? {DATA_WIDTH{1'b0}} : mem_r[rd_ptr_r];
  assign full    = full_s;
  assign empty   = empty_s;
  assign level   = level_r;

endmodule

// File: rtl/neural_stream_packer.sv
// Filters the per-sample stream by channel mask and decimation, packs accepted
// samples into sequence-numbered words and buffers them toward the CDC FIFO.
module neural_stream_packer
  import neural_acq_pkg::*;
#(
  parameter int DATA_WIDTH       = 16,
  parameter int CH_ID_WIDTH      = 4,
  parameter int NUM_CHANNELS     = 16,
  parameter int SAMPLES_PER_WORD = 4,
  parameter int FIFO_DEPTH_LOG2  = 3,
  parameter int DECIM_WIDTH      = 8,
  parameter int TIMEOUT_WIDTH    = 12,
  parameter int DROP_CNT_WIDTH   = 16,
  localparam int SLOT_W    = CH_ID_WIDTH + DATA_WIDTH,
  localparam int CNT_W     = cnt_width(SAMPLES_PER_WORD),
  localparam int OUT_WIDTH = SEQ_W + CNT_W + SAMPLES_PER_WORD*SLOT_W
) (
  input  logic                       sys_clk,
  input  logic                       sys_rst_n,
  input  logic [DATA_WIDTH-1:0]      in_data,
  input  logic [CH_ID_WIDTH-1:0]     in_channel,
  input  logic                       in_valid,
  input  logic                       cfg_enable,
  input  logic [NUM_CHANNELS-1:0]    cfg_ch_mask,
  input  logic [DECIM_WIDTH-1:0]     cfg_decim,
  input  logic [TIMEOUT_WIDTH-1:0]   cfg_timeout,
  input  logic                       flush_req,
  input  logic                       clear_stats,
  output logic [OUT_WIDTH-1:0]       out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DROP_CNT_WIDTH-1:0]  drop_cnt,
  output logic                       overflow_sticky,
  output logic [FIFO_DEPTH_LOG2:0]   fifo_level
);

  localparam int IDX_W   = $clog2(SAMPLES_PER_WORD);
  localparam int SLOTS_W = SAMPLES_PER_WORD * SLOT_W;

  logic [DECIM_WIDTH-1:0]    dcnt_r [NUM_CHANNELS];
  logic [0:0]                state_r;
  logic [IDX_W-1:0]          idx_r;
  logic [SLOTS_W-1:0]        slots_r;
  logic [TIMEOUT_WIDTH-1:0]  tcnt_r;
  logic [SEQ_W-1:0]          seq_r;
  logic                      push_r;
  logic [OUT_WIDTH-1:0]      push_word_r;
  logic [DROP_CNT_WIDTH-1:0] drop_cnt_r;
  logic                      overflow_sticky_r;

  logic                      mask_hit_s;
  logic [DECIM_WIDTH-1:0]    dcnt_sel_s;
  logic                      track_s;
  logic                      accept_s;
  logic                      in_fill_s;
  logic                      last_slot_s;
  logic                      timeout_hit_s;
  logic                      emit_s;
  logic [SLOTS_W-1:0]        word_slots_s;
  logic [CNT_W-1:0]          n_valid_s;
  logic                      fifo_full_s;
  logic                      fifo_empty_s;
  logic                      pop_s;
  logic                      drop_s;

  // channel lookup; IDs at or above NUM_CHANNELS match nothing and are ignored
  always_comb begin
    mask_hit_s = 1'b0;
    dcnt_sel_s = {DECIM_WIDTH{1'b0}};
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (in_channel == CH_ID_WIDTH'(c)) begin
        mask_hit_s = cfg_ch_mask[c];
        dcnt_sel_s = dcnt_r[c];
      end else begin
        mask_hit_s = mask_hit_s;
        dcnt_sel_s = dcnt_sel_s;
      end
    end
  end

  assign track_s       = in_valid && cfg_enable && mask_hit_s;
  assign accept_s      = track_s && (dcnt_sel_s == {DECIM_WIDTH{1'b0}});
  assign in_fill_s     = (state_r == ST_FILL);
  assign last_slot_s   = (idx_r == IDX_W'(SAMPLES_PER_WORD-1));
  assign timeout_hit_s = in_fill_s && (cfg_timeout != {TIMEOUT_WIDTH{1'b0}}) &&
                         (({1'b0, tcnt_r} + {{TIMEOUT_WIDTH{1'b0}}, 1'b1}) == {1'b0, cfg_timeout});
  assign emit_s        = cfg_enable &&
                         ((accept_s && last_slot_s) ||
                          ((flush_req || timeout_hit_s) && (in_fill_s || accept_s)));
  assign n_valid_s     = CNT_W'(idx_r) + CNT_W'(accept_s);

  // an accepted sample is merged into the word being emitted in the same cycle
  always_comb begin
    word_slots_s = slots_r;
    if (accept_s) begin
      word_slots_s[idx_r*SLOT_W +: SLOT_W] = {in_channel, in_data};
    end else begin
      word_slots_s = slots_r;
    end
  end

  // per-channel decimation counters; a keep-all ratio pins them at zero
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        dcnt_r[c] <= {DECIM_WIDTH{1'b0}};
      end
    end else begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        if (!cfg_enable || (cfg_decim <= DECIM_WIDTH'(1))) begin
          dcnt_r[c] <= {DECIM_WIDTH{1'b0}};
        end else if (track_s && (in_channel == CH_ID_WIDTH'(c))) begin
          dcnt_r[c] <= (dcnt_r[c] >= cfg_decim - DECIM_WIDTH'(1)) ? {DECIM_WIDTH{1'b0}}
                                                                : dcnt_r[c] + DECIM_WIDTH'(1);
        end
      end
    end
  end

  // packing FSM, slot storage, flush timer and sequence number
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_r <= ST_IDLE;
      idx_r   <= {IDX_W{1'b0}};
      slots_r <= {SLOTS_W{1'b0}};
      tcnt_r  <= {TIMEOUT_WIDTH{1'b0}};
      seq_r   <= {SEQ_W{1'b0}};
    end else if (!cfg_enable) begin
      state_r <= ST_IDLE;
      idx_r   <= {IDX_W{1'b0}};
      slots_r <= {SLOTS_W{1'b0}};
      tcnt_r  <= {TIMEOUT_WIDTH{1'b0}};
    end else if (emit_s) begin
      state_r <= ST_IDLE;
      idx_r   <= {IDX_W{1'b0}};
      slots_r <= {SLOTS_W{1'b0}};
      tcnt_r  <= {TIMEOUT_WIDTH{1'b0}};
      seq_r   <= seq_r + SEQ_W'(1);
    end else if (accept_s) begin
      state_r <= ST_FILL;
      idx_r   <= idx_r + IDX_W'(1);
      slots_r <= word_slots_s;
      tcnt_r  <= {TIMEOUT_WIDTH{1'b0}};
    end else if (in_fill_s && (tcnt_r != {TIMEOUT_WIDTH{1'b1}})) begin
      tcnt_r <= tcnt_r + TIMEOUT_WIDTH'(1);
    end
  end

  // one-cycle push stage between emission and the word FIFO
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      push_r      <= 1'b0;
      push_word_r <= {OUT_WIDTH{1'b0}};
    end else begin
      push_r <= emit_s;
      if (emit_s) begin
        push_word_r <= {seq_r, n_valid_s, word_slots_s};
      end
    end
  end

  neural_sync_fifo #(
    .DATA_WIDTH (OUT_WIDTH),
    .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
  ) u_word_fifo (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .wr_en     (push_r),
    .wr_data   (push_word_r),
    .rd_en     (out_ready),
    .rd_data   (out_data),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s),
    .level     (fifo_level)
  );

  assign pop_s  = !fifo_empty_s && out_ready;
  assign drop_s = push_r && fifo_full_s && !pop_s;

  // drop statistics; a drop in the same cycle as a clear still counts
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      drop_cnt_r        <= {DROP_CNT_WIDTH{1'b0}};
      overflow_sticky_r <= 1'b0;
    end else if (drop_s) begin
      overflow_sticky_r <= 1'b1;
      if (clear_stats) begin
        drop_cnt_r <= DROP_CNT_WIDTH'(1);
      end else if (drop_cnt_r != {DROP_CNT_WIDTH{1'b1}}) begin
        drop_cnt_r <= drop_cnt_r + DROP_CNT_WIDTH'(1);
      end
    end else if (clear_stats) begin
      drop_cnt_r        <= {DROP_CNT_WIDTH{1'b0}};
      overflow_sticky_r <= 1'b0;
    end
  end

  assign out_valid       = !fifo_empty_s;
  assign drop_cnt        = drop_cnt_r;
  assign overflow_sticky = overflow_sticky_r;

endmodule

// File: doc/neural_stream_packer.md
Name: neural_stream_packer

Overview:
Single-clock (sys_clk) successor to the framer stage of the acquisition pipeline. It takes the aggregated per-sample stream (data + channel ID) and filters it by a per-channel enable mask and per-channel decimation. It packs SAMPLES_PER_WORD accepted samples into one wide word with a sequence/count header, and buffers words in an internal FIFO. Output is a valid/ready stream toward the CDC FIFO. Drop and overflow statistics are provided for the CSR block.

Parameters:
DATA_WIDTH, 16, sample width
CH_ID_WIDTH, 4, channel ID width
NUM_CHANNELS, 16, channel count (≤ 2**CH_ID_WIDTH)
SAMPLES_PER_WORD, 4, slots per output word (≥ 2)
FIFO_DEPTH_LOG2, 3, internal word FIFO depth = 2**FIFO_DEPTH_LOG2
DECIM_WIDTH, 8, decimation ratio width
TIMEOUT_WIDTH, 12, flush-timeout counter width
DROP_CNT_WIDTH, 16, drop counter width
Derived localparams:
SLOT_W = CH_ID_WIDTH + DATA_WIDTH
CNT_W = $clog2(SAMPLES_PER_WORD+1)
OUT_WIDTH = 8 + CNT_W + SAMPLES_PER_WORD*SLOT_W

Ports:
sys_clk  in  1  clock
sys_rst_n  in  1  async active-low reset
in_data  in  DATA_WIDTH  sample
in_channel  in  CH_ID_WIDTH  channel ID
in_valid  in  1  sample strobe (no backpressure)
cfg_enable  in  1  packer enable
cfg_ch_mask  in  NUM_CHANNELS  per-channel accept mask
cfg_decim  in  DECIM_WIDTH  keep 1 of N per channel; 0/1 = keep all
cfg_timeout  in  TIMEOUT_WIDTH  partial-word flush timeout in cycles; 0 = disabled
flush_req  in  1  pulse: emit partial word now
clear_stats  in  1  pulse: clear drop_cnt/overflow_sticky
out_data  out  OUT_WIDTH  {seq[7:0], n_valid[CNT_W], slot[SPW-1]..slot[0]}; slot = {ch, data}
out_valid  out  1  word available
out_ready  in  1  consumer accepts
drop_cnt  out  DROP_CNT_WIDTH  words dropped on FIFO full, saturating
overflow_sticky  out  1  set on any drop
fifo_level  out  FIFO_DEPTH_LOG2+1  words buffered

Behaviour:
- Reset: all outputs 0; slot index 0; seq 0; decimation counters 0; FIFO empty.
- Accept condition: in_valid && cfg_enable && channel < NUM_CHANNELS && cfg_ch_mask[ch] && dcnt[ch]==0.
- Per-channel decimation:
  - On every in_valid for a masked-in channel, dcnt[ch] advances: if dcnt == cfg_decim-1 then 0, else +1.
  - With cfg_decim ≤ 1, dcnt stays 0.
- Out-of-range channel IDs are ignored and do not count as drops.
- Packing FSM:
  - IDLE (idx=0) and FILL (idx>0).
  - An accepted sample writes slot[idx]. Unused slots are zero.
  - Word emission happens when:
    - the accepted sample fills the last slot;
    - flush_req is asserted in FILL;
    - the timeout counter reaches cfg_timeout in FILL.
  - On emission: push {seq, n_valid, slots}, then seq++ (wraps at 8 bits), idx←0, return to IDLE.
  - Latency: from last sample accept to the FIFO push edge is 1 cycle. out_valid rises the cycle after the push.
- Simultaneous accept and flush/timeout: the sample is included in the emitted word, so n_valid counts it.
- flush_req or timeout in IDLE with no sample accepted: no-op.
- Timeout counter:
  - Cleared on every accept and on emission.
  - Increments each cycle while in FILL.
- FIFO full at push:
  - The word is dropped.
  - seq still increments, so the host detects the gap.
  - drop_cnt++ (saturates at all-ones); overflow_sticky←1.
- Push and pop in the same cycle when full: the pop frees a slot and the push succeeds (no drop).
- clear_stats: drop_cnt←0 and sticky←0. If it coincides with a drop, the drop wins: drop_cnt=1, sticky=1.
- Output handshake:
  - Show-ahead: out_valid = !empty, out_data = head word.
  - Pop on out_valid && out_ready.
  - out_data is stable while out_valid && !out_ready.
- cfg_enable 1→0 mid-packet:
  - The partial word is discarded, idx←0, all dcnt←0, seq is held.
  - FIFO contents keep draining.
- cfg_ch_mask or cfg_decim changes take effect on the next sample; dcnt is not cleared.

Decomposition:
- Package neural_acq_pkg:
  - slot_t struct {ch, data}
  - word-header widths (SEQ_W=8)
  - packer state enum {IDLE, FILL}
- Sub-module: neural_sync_fifo (single-clock show-ahead FIFO, DATA_WIDTH/DEPTH_LOG2 parameters, full/empty/level outputs), reusable by other sys_clk stages.

Test Plan:
- Defaults, mask=16'hFFFF, decim=1, channels 0,1,2,3 with data 0x0A..0x0D, out_ready=1 -> one word: seq=0, n_valid=4, slots {0,0x0A}..{3,0x0D}; out_valid 2 cycles after the 4th sample.
- mask=16'h0004, decim=3, 12 samples of channel 2 -> only samples 1, 4, 7, 10 accepted; one word, n_valid=4.
- Timeout: timeout=10, 2 samples then idle -> word with n_valid=2 and slots 2–3 zero, pushed 10 cycles after the last accept; flush_req in IDLE produces nothing.
- Backpressure: out_ready=0, emit 9 words at depth 8 -> fifo_level=8, drop_cnt=1, sticky=1. Then drain: seq values 0..7 out, and the next emitted word has seq=9.
- clear_stats in the same cycle as a drop -> drop_cnt=1, sticky=1. A clear_stats alone -> 0, 0.
- cfg_enable dropped after 3 samples, re-enabled, 4 new samples -> a single word containing only the new samples, seq continuous. The async reset asserted mid-FILL clears all state and outputs immediately.
